// File: rtl/ppu_bg_pixel_pipe.sv
// Background pixel pipeline: fetches one scanline of BG tile rows from VRAM,
// buffers decoded colours in a pixel FIFO, drops the SCX fine-scroll pixels
// and emits BGP-shaded pixels over a valid/ready handshake.
module ppu_bg_pixel_pipe #(
    parameter int LINE_W     = 160,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [7:0]        lcdc,
    input  logic [7:0]        scx,
    input  logic [7:0]        scy,
    input  logic [7:0]        ly,
    input  logic [7:0]        bgp,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_ack,
    input  logic [7:0]        vram_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [1:0]        px_shade,
    output logic              busy,
    output logic              line_done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int EMIT_W = $clog2(LINE_W + 1);
    localparam int PUSH_W = $clog2(LINE_W + 9);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FETCH_NO   = 3'd1;
    localparam logic [2:0] FETCH_LO   = 3'd2;
    localparam logic [2:0] FETCH_HI   = 3'd3;
    localparam logic [2:0] WAIT_SPACE = 3'd4;
    localparam logic [2:0] PUSH       = 3'd5;
    localparam logic [2:0] DRAIN      = 3'd6;

    // Control state
    logic [2:0]        state_q, state_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bg_en_q, bg_en_d;
    logic              map_sel_q, map_sel_d;
    logic              tdata_q, tdata_d;
    logic [4:0]        scx_hi_q, scx_hi_d;
    logic [7:0]        bgp_q, bgp_d;
    logic [7:0]        y_q, y_d;
    logic [4:0]        tile_idx_q, tile_idx_d;
    logic [2:0]        discard_q, discard_d;
    logic [EMIT_W-1:0] emitted_q, emitted_d;
    logic [PUSH_W-1:0] pushed_q, pushed_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Fetched tile data and pixel storage (no reset needed)
    logic [7:0]        tnum_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;
    logic [1:0]        mem_q [FIFO_DEPTH];

    logic              ack_ok;
    logic              fifo_ne;
    logic              accept;
    logic              drop;
    logic              pop;
    logic              push;
    logic              last_px;
    logic [4:0]        col;
    logic [15:0]       map_addr;
    logic [15:0]       tile_base;
    logic [15:0]       lo_addr;
    logic [15:0]       sel_addr;
    logic [1:0]        head_c;
    logic [1:0]        eff_c;

    // Handshake and FIFO side-conditions for the current cycle
    always_comb begin
        ack_ok   = rd_q && vram_ack;
        fifo_ne  = (cnt_q != '0);
        px_valid = busy_q && fifo_ne && (discard_q == 3'd0) && (emitted_q < EMIT_W'(LINE_W));
        accept   = px_valid && px_ready;
        drop     = busy_q && fifo_ne && (discard_q != 3'd0);
        pop      = accept || drop;
        push     = busy_q && (state_q == PUSH);
        last_px  = accept && (emitted_q == EMIT_W'(LINE_W - 1));
    end

    // VRAM address generation for the map, low and high bitplane reads
    always_comb begin
        col       = scx_hi_q + tile_idx_q;
        map_addr  = (map_sel_q ? 16'h9C00 : 16'h9800) + {6'b0, y_q[7:3], 5'b0} + {11'b0, col};
        tile_base = tdata_q ? (16'h8000 + {4'b0, tnum_q, 4'b0})
                            : (16'h9000 + {{4{tnum_q[7]}}, tnum_q, 4'b0});
        lo_addr   = tile_base + {12'b0, y_q[2:0], 1'b0};
        case (state_q)
            FETCH_LO: sel_addr = lo_addr;
            FETCH_HI: sel_addr = lo_addr + 16'd1;
            default:  sel_addr = map_addr;
        endcase
        vram_addr = rd_q ? ADDR_W'(sel_addr) : '0;
        vram_rd   = rd_q;
    end

    // Shade the FIFO head through the snapshot palette
    always_comb begin
        head_c    = mem_q[rd_ptr_q];
        eff_c     = bg_en_q ? head_c : 2'b00;
        px_shade  = px_valid ? bgp_q[{eff_c, 1'b0} +: 2] : 2'b00;
        busy      = busy_q;
        line_done = done_q;
    end

    // Next-state: line snapshot, fetch sequencing, FIFO bookkeeping, end of line
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bg_en_d    = bg_en_q;
        map_sel_d  = map_sel_q;
        tdata_d    = tdata_q;
        scx_hi_d   = scx_hi_q;
        bgp_d      = bgp_q;
        y_d        = y_q;
        tile_idx_d = tile_idx_q;
        discard_d  = discard_q;
        emitted_d  = emitted_q;
        pushed_d   = pushed_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;

        if (line_start) begin
            bg_en_d    = lcdc[0];
            map_sel_d  = lcdc[3];
            tdata_d    = lcdc[4];
            scx_hi_d   = scx[7:3];
            bgp_d      = bgp;
            y_d        = scy + ly;
            tile_idx_d = 5'd0;
            discard_d  = scx[2:0];
            emitted_d  = '0;
            pushed_d   = '0;
            busy_d     = 1'b1;
            state_d    = FETCH_NO;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
        end else if (busy_q) begin
            case (state_q)
                FETCH_NO:   if (ack_ok) state_d = FETCH_LO;
                FETCH_LO:   if (ack_ok) state_d = FETCH_HI;
                FETCH_HI:   if (ack_ok) state_d = WAIT_SPACE;
                WAIT_SPACE: if (cnt_q <= CNT_W'(FIFO_DEPTH - 8)) state_d = PUSH;
                PUSH: begin
                    tile_idx_d = tile_idx_q + 5'd1;
                    pushed_d   = pushed_q + PUSH_W'(8);
                    // Enough tiles to cover LINE_W plus up to 7 discarded pixels
                    state_d    = (pushed_q < PUSH_W'(LINE_W)) ? FETCH_NO : DRAIN;
                end
                default: ;
            endcase

            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(8);
            cnt_d = cnt_q + (push ? CNT_W'(8) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
            if (drop)   discard_d = discard_q - 3'd1;
            if (accept) emitted_d = emitted_q + EMIT_W'(1);

            if (last_px) begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
            end
        end

        // A fresh line starts with the read port released for one cycle
        rd_d = !line_start &&
               ((state_d == FETCH_NO) || (state_d == FETCH_LO) || (state_d == FETCH_HI));
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bg_en_q    <= 1'b0;
            map_sel_q  <= 1'b0;
            tdata_q    <= 1'b0;
            scx_hi_q   <= 5'd0;
            bgp_q      <= 8'd0;
            y_q        <= 8'd0;
            tile_idx_q <= 5'd0;
            discard_q  <= 3'd0;
            emitted_q  <= '0;
            pushed_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bg_en_q    <= bg_en_d;
            map_sel_q  <= map_sel_d;
            tdata_q    <= tdata_d;
            scx_hi_q   <= scx_hi_d;
            bgp_q      <= bgp_d;
            y_q        <= y_d;
            tile_idx_q <= tile_idx_d;
            discard_q  <= discard_d;
            emitted_q  <= emitted_d;
            pushed_q   <= pushed_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Capture VRAM bytes on acknowledge and write a decoded tile row, MSB pixel first
    always_ff @(posedge clk) begin
        if (ack_ok && (state_q == FETCH_NO)) tnum_q <= vram_data;
        if (ack_ok && (state_q == FETCH_LO)) lo_q   <= vram_data;
        if (ack_ok && (state_q == FETCH_HI)) hi_q   <= vram_data;
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= {hi_q[7-i], lo_q[7-i]};
            end
        end
    end

endmodule
